// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants.
package riscv_pkg;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_FLUSH
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: power-of-two circular FIFO with synchronous clear and
// simultaneous push/pop at any occupancy, including full.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     clear,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head_data
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (PW+1)'(DEPTH));
    assign count     = r_count;
    assign head_data = r_mem[r_rd_ptr];

    // A pop frees the slot this cycle, so a push into a full FIFO is legal with it.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !clear) r_mem[r_wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word-aligned requests, buffers in-order
// responses with their PCs, and drops stale responses after a redirect.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned      WIDTH      = 32,
    parameter int unsigned      FIFO_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_req_ready,
    input  logic             imem_resp_valid,
    input  logic [WIDTH-1:0] imem_resp_data,
    input  logic             redirect_en,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             stop_fetch,
    output logic             f2d_valid,
    output logic [WIDTH-1:0] f2d_instr,
    output logic [WIDTH-1:0] f2d_pc,
    input  logic             f2d_ready
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t     r_state;
    logic [WIDTH-1:0] r_fetch_pc;
    logic [WIDTH-1:0] r_resp_pc;
    logic [CW-1:0]    r_outstanding_cnt;
    logic [CW-1:0]    r_discard_cnt;

    logic             w_req_fire;
    logic             w_pop;
    logic             w_push;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [CW-1:0]    w_fifo_count;
    logic [2*WIDTH-1:0] w_head;
    logic [WIDTH-1:0] w_redir_pc;
    logic [CW-1:0]    w_discard_next;

    // Credit check counts in-flight requests as already occupying buffer slots.
    assign imem_req_valid = (r_state == S_RUN) && !redirect_en && !stop_fetch &&
                            (({1'b0, r_outstanding_cnt} + {1'b0, w_fifo_count}) <
                             (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid & imem_req_ready;

    assign f2d_valid = ~w_fifo_empty;
    assign f2d_instr = f2d_valid ? w_head[2*WIDTH-1:WIDTH] : '0;
    assign f2d_pc    = f2d_valid ? w_head[WIDTH-1:0] : '0;

    assign w_pop  = f2d_valid & f2d_ready & ~redirect_en;
    assign w_push = imem_resp_valid & (r_discard_cnt == '0) & ~redirect_en &
                    (~w_fifo_full | w_pop);

    assign w_redir_pc     = redirect_pc & ~(WIDTH'(INSTR_BYTES - 1));
    assign w_discard_next = r_outstanding_cnt - CW'(imem_resp_valid);

    fetch_fifo #(
        .WIDTH (2 * WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data ({imem_resp_data, r_resp_pc}),
        .pop       (w_pop),
        .clear     (redirect_en),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count),
        .head_data (w_head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state           <= S_BOOT;
            r_fetch_pc        <= RESET_PC;
            r_resp_pc         <= RESET_PC;
            r_outstanding_cnt <= '0;
            r_discard_cnt     <= '0;
        end else begin
            unique case ({w_req_fire, imem_resp_valid})
                2'b10:   r_outstanding_cnt <= r_outstanding_cnt + CW'(1);
                2'b01:   r_outstanding_cnt <= r_outstanding_cnt - CW'(1);
                default: r_outstanding_cnt <= r_outstanding_cnt;
            endcase

            if (redirect_en) begin
                // Everything still in flight belongs to the old path.
                r_fetch_pc    <= w_redir_pc;
                r_resp_pc     <= w_redir_pc;
                r_discard_cnt <= w_discard_next;
                r_state       <= (w_discard_next != '0) ? S_FLUSH : S_RUN;
            end else begin
                if (w_req_fire) r_fetch_pc <= r_fetch_pc + WIDTH'(INSTR_BYTES);
                if (imem_resp_valid) begin
                    if (r_discard_cnt == '0) r_resp_pc <= r_resp_pc + WIDTH'(INSTR_BYTES);
                    else                     r_discard_cnt <= r_discard_cnt - CW'(1);
                end
                case (r_state)
                    S_BOOT:  r_state <= S_RUN;
                    S_RUN:   r_state <= S_RUN;
                    S_FLUSH: begin
                        if (r_discard_cnt == '0 ||
                            (r_discard_cnt == CW'(1) && imem_resp_valid)) begin
                            r_state <= S_RUN;
                        end
                    end
                    default: r_state <= S_BOOT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency in-order memory model.
module tb_fetch_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stop_fetch = 1'b0;
    logic        f2d_valid;
    logic [31:0] f2d_instr;
    logic [31:0] f2d_pc;
    logic        f2d_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .WIDTH      (32),
        .FIFO_DEPTH (4),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_en     (redirect_en),
        .redirect_pc     (redirect_pc),
        .stop_fetch      (stop_fetch),
        .f2d_valid       (f2d_valid),
        .f2d_instr       (f2d_instr),
        .f2d_pc          (f2d_pc),
        .f2d_ready       (f2d_ready)
    );

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    mem_req_t mem_q[$];
    mem_req_t mem_e;
    int       mem_lat = 1;
    int       cyc = 0;

    // Memory: a request accepted in cycle c is answered in cycle c + mem_lat.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q.delete();
            cyc = 0;
            imem_resp_valid <= 1'b0;
            imem_resp_data  <= '0;
        end else begin
            if (imem_resp_valid) mem_q.delete(0);
            if (imem_req_valid && imem_req_ready) begin
                mem_e.addr = imem_req_addr;
                mem_e.due  = cyc + mem_lat;
                mem_q.push_back(mem_e);
            end
            cyc++;
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                imem_resp_valid <= 1'b1;
                imem_resp_data  <= mem_data(mem_q[0].addr);
            end else begin
                imem_resp_valid <= 1'b0;
                imem_resp_data  <= '0;
            end
        end
    end

    task automatic do_reset(input int lat, input logic rdy);
        rst            = 1'b1;
        mem_lat        = lat;
        f2d_ready      = rdy;
        imem_req_ready = 1'b1;
        redirect_en    = 1'b0;
        redirect_pc    = '0;
        stop_fetch     = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid);
        end
        n_tests++;
        if (imem_req_addr !== 32'h0) begin
            n_fail++; $display("FAIL reset_req_addr: got %h want 00000000", imem_req_addr);
        end
        n_tests++;
        if (f2d_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_f2d_valid: got %b want 0", f2d_valid);
        end
        n_tests++;
        if (f2d_instr !== 32'h0 || f2d_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_f2d_data: got instr %h pc %h want 0 0", f2d_instr, f2d_pc);
        end
    endtask

    task automatic test_boot_stream();
        do_reset(1, 1'b1);
        @(negedge clk);
        n_tests++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || f2d_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL boot_c1: got v=%b a=%h f2d=%b want 1 00000000 0",
                     imem_req_valid, imem_req_addr, f2d_valid);
        end
        @(negedge clk);
        n_tests++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4 || f2d_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL boot_c2: got v=%b a=%h f2d=%b want 1 00000004 0",
                     imem_req_valid, imem_req_addr, f2d_valid);
        end
        @(negedge clk);
        n_tests++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin
            n_fail++;
            $display("FAIL boot_c3_req: got v=%b a=%h want 1 00000008",
                     imem_req_valid, imem_req_addr);
        end
        n_tests++;
        if (f2d_valid !== 1'b1 || f2d_pc !== 32'h0 || f2d_instr !== mem_data(32'h0)) begin
            n_fail++;
            $display("FAIL boot_c3_f2d: got v=%b pc=%h i=%h want 1 00000000 %h",
                     f2d_valid, f2d_pc, f2d_instr, mem_data(32'h0));
        end
    endtask

    task automatic test_req_stall();
        do_reset(1, 1'b1);
        @(negedge clk);
        imem_req_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL stall_hold: got v=%b a=%h want 1 00000000",
                     imem_req_valid, imem_req_addr);
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (imem_req_addr !== 32'h4) begin
            n_fail++; $display("FAIL stall_advance: got %h want 00000004", imem_req_addr);
        end
    endtask

    task automatic test_backpressure();
        int n_req;
        int got;
        n_req = 0;
        do_reset(1, 1'b0);
        repeat (10) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) n_req++;
        end
        n_tests++;
        if (n_req !== 4) begin
            n_fail++; $display("FAIL bp_req_count: got %0d want 4", n_req);
        end
        n_tests++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_req_blocked: got %b want 0", imem_req_valid);
        end
        f2d_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && got < 4; i++) begin
            if (f2d_valid && f2d_ready) begin
                n_tests++;
                if (f2d_pc !== 32'(got * 4)) begin
                    n_fail++; $display("FAIL bp_pop_pc%0d: got %h want %h", got, f2d_pc, got * 4);
                end
                got++;
            end
            @(negedge clk);
        end
        n_tests++;
        if (got !== 4) begin
            n_fail++; $display("FAIL bp_pop_count: got %0d want 4", got);
        end
    endtask

    task automatic test_redirect_flush();
        logic        seen_req;
        logic        seen_f2d;
        logic [31:0] req_a;
        logic [31:0] pc_s;
        logic [31:0] ins_s;
        seen_req = 1'b0; seen_f2d = 1'b0;
        req_a = '0; pc_s = '0; ins_s = '0;
        do_reset(3, 1'b1);
        repeat (3) @(negedge clk);
        redirect_en = 1'b1;
        redirect_pc = 32'h0000_0042;
        #1;
        n_tests++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_req_blocked: got %b want 0", imem_req_valid);
        end
        @(negedge clk);
        redirect_en = 1'b0;
        #1;
        for (int i = 0; i < 20 && !seen_f2d; i++) begin
            if (!seen_req && imem_req_valid) begin
                seen_req = 1'b1; req_a = imem_req_addr;
            end
            if (f2d_valid) begin
                seen_f2d = 1'b1; pc_s = f2d_pc; ins_s = f2d_instr;
            end
            @(negedge clk); #1;
        end
        n_tests++;
        if (seen_req !== 1'b1 || req_a !== 32'h40) begin
            n_fail++; $display("FAIL flush_first_req: got %b %h want 1 00000040", seen_req, req_a);
        end
        n_tests++;
        if (seen_f2d !== 1'b1 || pc_s !== 32'h40 || ins_s !== mem_data(32'h40)) begin
            n_fail++;
            $display("FAIL flush_first_f2d: got v=%b pc=%h i=%h want 1 00000040 %h",
                     seen_f2d, pc_s, ins_s, mem_data(32'h40));
        end
    endtask

    task automatic test_redirect_collide();
        do_reset(1, 1'b0);
        repeat (3) @(negedge clk);
        n_tests++;
        if (f2d_valid !== 1'b1 || imem_resp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL collide_setup: got f2d=%b resp=%b want 1 1", f2d_valid, imem_resp_valid);
        end
        f2d_ready   = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = 32'h0000_0103;
        @(negedge clk);
        redirect_en = 1'b0;
        #1;
        n_tests++;
        if (f2d_valid !== 1'b0) begin
            n_fail++; $display("FAIL collide_fifo_empty: got %b want 0", f2d_valid);
        end
        n_tests++;
        if (dut.r_state !== S_RUN || dut.r_discard_cnt !== '0) begin
            n_fail++;
            $display("FAIL collide_state: got state=%0d discard=%0d want %0d 0",
                     dut.r_state, dut.r_discard_cnt, S_RUN);
        end
        n_tests++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL collide_req: got v=%b a=%h want 1 00000100",
                     imem_req_valid, imem_req_addr);
        end
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (f2d_valid !== 1'b1 || f2d_pc !== 32'h100 || f2d_instr !== mem_data(32'h100)) begin
            n_fail++;
            $display("FAIL collide_f2d: got v=%b pc=%h i=%h want 1 00000100 %h",
                     f2d_valid, f2d_pc, f2d_instr, mem_data(32'h100));
        end
    endtask

    task automatic test_wrap();
        do_reset(1, 1'b1);
        @(negedge clk);
        redirect_en = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        @(negedge clk);
        redirect_en = 1'b0;
        #1;
        n_tests++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFF8) begin
            n_fail++;
            $display("FAIL wrap_a0: got v=%b a=%h want 1 fffffff8", imem_req_valid, imem_req_addr);
        end
        @(negedge clk);
        n_tests++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_a1: got v=%b a=%h want 1 fffffffc", imem_req_valid, imem_req_addr);
        end
        @(negedge clk);
        n_tests++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_a2: got v=%b a=%h want 1 00000000", imem_req_valid, imem_req_addr);
        end
        n_tests++;
        if (f2d_valid !== 1'b1 || f2d_pc !== 32'hFFFF_FFF8) begin
            n_fail++; $display("FAIL wrap_f2d: got v=%b pc=%h want 1 fffffff8", f2d_valid, f2d_pc);
        end
    endtask

    task automatic test_stop_fetch();
        int n_req;
        int n_pop;
        n_req = 0; n_pop = 0;
        do_reset(2, 1'b0);
        repeat (4) @(negedge clk);
        n_tests++;
        if (f2d_valid !== 1'b1 || f2d_pc !== 32'h0) begin
            n_fail++; $display("FAIL stop_setup: got v=%b pc=%h want 1 00000000", f2d_valid, f2d_pc);
        end
        stop_fetch = 1'b1;
        f2d_ready  = 1'b1;
        #1;
        for (int i = 0; i < 15; i++) begin
            if (imem_req_valid && imem_req_ready) n_req++;
            if (f2d_valid && f2d_ready) begin
                if (n_pop < 3) begin
                    n_tests++;
                    if (f2d_pc !== 32'(n_pop * 4)) begin
                        n_fail++;
                        $display("FAIL stop_pop_pc%0d: got %h want %h", n_pop, f2d_pc, n_pop * 4);
                    end
                end
                n_pop++;
            end
            @(negedge clk); #1;
        end
        n_tests++;
        if (n_req !== 0) begin
            n_fail++; $display("FAIL stop_no_req: got %0d want 0", n_req);
        end
        n_tests++;
        if (n_pop !== 3) begin
            n_fail++; $display("FAIL stop_pop_count: got %0d want 3", n_pop);
        end
        n_tests++;
        if (f2d_valid !== 1'b0) begin
            n_fail++; $display("FAIL stop_drained: got %b want 0", f2d_valid);
        end
    endtask

    task automatic test_mid_reset();
        do_reset(1, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if (f2d_valid !== 1'b0 || imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got f2d=%b v=%b a=%h want 0 0 00000000",
                     f2d_valid, imem_req_valid, imem_req_addr);
        end
        n_tests++;
        if (dut.r_outstanding_cnt !== '0) begin
            n_fail++; $display("FAIL midrst_outstanding: got %0d want 0", dut.r_outstanding_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_boot_stream();
        test_req_stall();
        test_backpressure();
        test_redirect_flush();
        test_redirect_collide();
        test_wrap();
        test_stop_fetch();
        test_mid_reset();
        test_boot_stream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter WIDTH, default 32: address and instruction width in bits.
REQ-002 Parameter FIFO_DEPTH, default 4: number of instruction buffer entries, power of two, at least 2.
REQ-003 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 imem_req_valid  output  1  fetch request valid.
REQ-007 imem_req_addr  output  WIDTH  fetch address, word aligned.
REQ-008 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-009 imem_resp_valid  input  1  instruction word returned; responses arrive in request order with latency of 1 cycle or more.
REQ-010 imem_resp_data  input  WIDTH  returned instruction word.
REQ-011 redirect_en  input  1  taken branch from execute; flushes all fetch state.
REQ-012 redirect_pc  input  WIDTH  branch target.
REQ-013 stop_fetch  input  1  halt detected; blocks new requests only.
REQ-014 f2d_valid  output  1  f2d_instr/f2d_pc hold a valid entry for the IF/ID register.
REQ-015 f2d_instr  output  WIDTH  instruction to decode.
REQ-016 f2d_pc  output  WIDTH  PC of f2d_instr.
REQ-017 f2d_ready  input  1  IF/ID register advances this cycle.

Function
REQ-018 The FSM SHALL have three states:
- S_BOOT: entered on reset; moves to S_RUN after one cycle.
- S_RUN: normal fetching.
- S_FLUSH: entered on redirect while discard_cnt would be nonzero; returns to S_RUN when discard_cnt reaches 0.
REQ-019 imem_req_valid SHALL be 1 only when all of these hold, using current-cycle values with no pop bypass:
- state is S_RUN;
- redirect_en is 0 and stop_fetch is 0;
- outstanding_cnt plus fifo_count is less than FIFO_DEPTH.
REQ-020 imem_req_addr SHALL equal the fetch_pc register; on a request handshake (valid and ready both 1), fetch_pc advances by 4 modulo 2^WIDTH, so 32'hFFFF_FFFC wraps to 0.
REQ-021 outstanding_cnt (width clog2(FIFO_DEPTH)+1) SHALL increment on each request handshake and decrement on each imem_resp_valid, with a net change of 0 when both occur in the same cycle.
REQ-022 Responses SHALL be handled as follows:
- If discard_cnt is 0, the response is pushed into the FIFO as {imem_resp_data, resp_pc}, and resp_pc advances by 4.
- Otherwise the response is dropped and discard_cnt decrements.
REQ-023 A pushed entry SHALL first appear on the f2d outputs on the following cycle, giving a minimum request-to-f2d_valid latency of 2 cycles.
REQ-024 An entry SHALL pop when f2d_valid and f2d_ready are both 1.
REQ-025 Push and pop in the same cycle SHALL be permitted at any occupancy, including full; overflow is impossible by REQ-019.
REQ-026 When redirect_en is 1, redirect SHALL take priority over every other event in that cycle:
- the FIFO is cleared and any pop or push that cycle is ignored;
- fetch_pc and resp_pc are loaded with redirect_pc & ~3;
- discard_cnt is loaded with outstanding_cnt minus imem_resp_valid;
- next state is S_FLUSH if that value is nonzero, otherwise S_RUN.
REQ-027 A redirect received in S_FLUSH or S_BOOT SHALL be handled per REQ-026.
REQ-028 While f2d_valid is 0, f2d_instr and f2d_pc SHALL be driven to 0.
REQ-029 stop_fetch SHALL NOT discard in-flight responses or FIFO contents; they still drain to decode.

Reset
REQ-030 While rst is 1, the block SHALL hold these values:
- state S_BOOT;
- fetch_pc and resp_pc at RESET_PC;
- outstanding_cnt, discard_cnt and FIFO count at 0;
- imem_req_valid, f2d_valid, f2d_instr and f2d_pc at 0.
REQ-031 Reset asserted mid-operation SHALL abandon all in-flight requests; the memory model is reset together with this block.

Structure
REQ-032 The shared package riscv_pkg SHALL hold:
- typedef fetch_state_t (S_BOOT, S_RUN, S_FLUSH);
- constant INSTR_BYTES = 4;
- the default RESET_PC.
REQ-033 The instruction buffer SHALL be a separate sub-module fetch_fifo with:
- parameters WIDTH and DEPTH;
- ports clk, rst, push, push_data, pop, clear, full, empty, count, head_data.

Verification
REQ-034 Reset release with 1-cycle memory and f2d_ready held at 1 -> addresses 0, 4, 8 issued on consecutive cycles; f2d_pc = 0 with f2d_valid = 1 on the 3rd cycle after reset release.
REQ-035 f2d_ready = 0 with FIFO_DEPTH = 4 -> at most 4 requests issued, then imem_req_valid = 0; raising f2d_ready pops PCs 0, 4, 8, 12 in order.
REQ-036 Memory latency 3, redirect to 32'h0000_0042 with 2 requests in flight -> both stale responses dropped; next f2d_pc = 32'h0000_0040.
REQ-037 Redirect in the same cycle as a response and a pop, with 1 request outstanding -> FIFO empty, discard_cnt = 0, state S_RUN, next request addr = redirect_pc & ~3.
REQ-038 fetch_pc = 32'hFFFF_FFF8 -> requests 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000.
REQ-039 stop_fetch asserted with 2 requests in flight and 1 entry buffered -> no new requests; 3 entries delivered; f2d_valid then stays 0.
